// File: rtl/cntr_config_down_pkg.sv
// Shared definitions for the configurable down-counter: state encoding,
// step-decision encoding and the default count width.
package cntr_config_down_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HIT   = 2'd2,
    MISS  = 2'd3
  } state_t;

  // Outcome of one COUNT-state evaluation.
  typedef enum logic [1:0] {
    STEP_DEC  = 2'd0,
    STEP_HIT  = 2'd1,
    STEP_MISS = 2'd2
  } step_t;

endpackage

// File: rtl/cntr_config_down.sv
// Configurable down-counter: loads a start value, steps down by a latched
// decrement and reports whether the latched target is hit exactly or missed.
module cntr_config_down
  import cntr_config_down_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] cntr_start,
  input  logic [WIDTH-1:0] ind_val,
  input  logic [WIDTH-1:0] decr,
  output logic [WIDTH-1:0] cntr_out,
  output logic             ind,
  output logic             miss,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] ind_val_q;
  logic [WIDTH-1:0] decr_q;

  step_t            step;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] next_cnt;

  // Step check on latched config; the extra bit keeps the remaining
  // distance honest so an overshooting step is caught instead of wrapping.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    step     = STEP_DEC;
    diff     = {1'b0, cntr_out} - {1'b0, ind_val_q};
    next_cnt = cntr_out - decr_q;
    if (cntr_out == ind_val_q)           step = STEP_HIT;
    else if (cntr_out < ind_val_q)       step = STEP_MISS;
    else if (decr_q == '0)               step = STEP_MISS;
    else if ({1'b0, decr_q} > diff)      step = STEP_MISS;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cntr_out  <= '0;
      ind       <= 1'b0;
      miss      <= 1'b0;
      busy      <= 1'b0;
      ind_val_q <= '0;
      decr_q    <= '0;
    end else begin
      case (state)
        COUNT: begin
          case (step)
            STEP_HIT: begin
              ind   <= 1'b1;
              busy  <= 1'b0;
              state <= HIT;
            end
            STEP_MISS: begin
              miss  <= 1'b1;
              busy  <= 1'b0;
              state <= MISS;
            end
            default: cntr_out <= next_cnt;
          endcase
        end
        default: begin
          // IDLE, HIT and MISS all accept a new run; results hold otherwise.
          if (start) begin
            ind_val_q <= ind_val;
            decr_q    <= decr;
            cntr_out  <= cntr_start;
            ind       <= 1'b0;
            miss      <= 1'b0;
            busy      <= 1'b1;
            state     <= COUNT;
          end
        end
      endcase
    end
  end

endmodule
